// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall/flush control and E-stage forwarding selects.
// Latency: all outputs are combinational from the current state and inputs; state updates on the rising clk edge.
// Backpressure: a data-memory wait freezes F/D/E/M and bubbles W until the memory completes, or until the timeout latches an error.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs1D_i/Rs2D_i              source registers of the instruction in D
//   Rs1E_i/Rs2E_i, RdE_i       source and destination registers of the instruction in E
//   ResultSrcE_i               2'b01 marks a load in E
//   PCSrcE_i                   taken branch/jump resolved in E
//   RdM_i/RdW_i, RegWrite*_i   destinations and write enables of M and W
//   MemReqM_i, MemReadyM_i     M-stage data-memory request and completion
//   Stall*_o, Flush*_o         hold / bubble the stage registers
//   ForwardAE_o/ForwardBE_o    00 regfile, 01 W result, 10 M ALU result
//   InitDone_o, MemErr_o       post-reset flush finished, sticky memory timeout
// Optional feature: define HAZARD_PERF_EN to add the StallCnt_o / FlushCnt_o perf counters (width CNT_W).

module hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D_i,
    input  logic [4:0] Rs2D_i,
    input  logic [4:0] Rs1E_i,
    input  logic [4:0] Rs2E_i,
    input  logic [4:0] RdE_i,
    input  logic [1:0] ResultSrcE_i,
    input  logic       PCSrcE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    input  logic       MemReqM_i,
    input  logic       MemReadyM_i,
    output logic       StallF_o,
    output logic       StallD_o,
    output logic       StallE_o,
    output logic       StallM_o,
    output logic       FlushD_o,
    output logic       FlushE_o,
    output logic       FlushM_o,
    output logic       FlushW_o,
    output logic [1:0] ForwardAE_o,
    output logic [1:0] ForwardBE_o,
    output logic       InitDone_o,
    output logic       MemErr_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
`endif
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    // One spare bit so the incremented wait count never wraps before the compare.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2) + 1;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    logic mem_wait;
    logic lw_stall;
    logic timeout_hit;
    logic branch_flush;

    assign mem_wait  = MemReqM_i & ~MemReadyM_i;
    assign lw_stall  = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                       ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign wait_next = wait_cnt + 1'b1;
    // wait_cnt counts not-ready cycles already seen (the RUN cycle that entered the wait is #1).
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_next >= WAIT_W'(MEM_TIMEOUT));
    // Branch flush only wins in RUN when no memory wait is pending.
    assign branch_flush = (state == S_RUN) && !mem_wait && PCSrcE_i;

    // Forwarding select for one E-stage operand; M outranks W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs))
            return 2'b10;
        else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE_o = fwd_sel(Rs1E_i);
    assign ForwardBE_o = fwd_sel(Rs2E_i);

    always_comb begin
        StallF_o   = 1'b0;
        StallD_o   = 1'b0;
        StallE_o   = 1'b0;
        StallM_o   = 1'b0;
        FlushD_o   = 1'b0;
        FlushE_o   = 1'b0;
        FlushM_o   = 1'b0;
        FlushW_o   = 1'b0;
        InitDone_o = 1'b0;
        MemErr_o   = 1'b0;
        case (state)
            S_INIT: begin
                // Pipeline registers have no reset: flush them all while fetch is held.
                StallF_o = 1'b1;
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
                FlushM_o = 1'b1;
                FlushW_o = 1'b1;
            end
            S_RUN: begin
                InitDone_o = 1'b1;
                if (mem_wait) begin
                    StallF_o = 1'b1;
                    StallD_o = 1'b1;
                    StallE_o = 1'b1;
                    StallM_o = 1'b1;
                    FlushW_o = 1'b1;
                end else if (PCSrcE_i) begin
                    FlushD_o = 1'b1;
                    FlushE_o = 1'b1;
                end else if (lw_stall) begin
                    StallF_o = 1'b1;
                    StallD_o = 1'b1;
                    FlushE_o = 1'b1;
                end
            end
            S_MEM_WAIT, S_ERROR: begin
                // E is frozen, so a resolved branch there is acted on after release.
                InitDone_o = 1'b1;
                StallF_o   = 1'b1;
                StallD_o   = 1'b1;
                StallE_o   = 1'b1;
                StallM_o   = 1'b1;
                FlushW_o   = 1'b1;
                MemErr_o   = (state == S_ERROR);
            end
            default: begin
                StallF_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1))
                        state <= S_RUN;
                    else
                        init_cnt <= init_cnt + 1'b1;
                end
                S_RUN: begin
                    if (mem_wait) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (MemReadyM_i) begin
                        state <= S_RUN;
                    end else begin
                        wait_cnt <= wait_next;
                        if (timeout_hit)
                            state <= S_ERROR;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state != S_INIT) && StallF_o)
                stall_cnt <= stall_cnt + 1'b1;
            if (branch_flush)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign StallCnt_o = stall_cnt;
    assign FlushCnt_o = flush_cnt;
`else
    // Only the perf counters consume the branch-flush qualifier.
    logic unused_perf;
    assign unused_perf = branch_flush;
`endif

endmodule
